gate_store_clear_seq: RTL and testbench

- Parametrised store/clear sequencer for the frequency/period meter counters. It runs on CLK_50 and watches the gate window (Enable) and the counter overflow (OF).
- After each gate window closes, it drives a Store pulse (latch the counters to the display registers), then a Clear pulse (zero the counters), then returns to ready.
- Successor to the fixed-width store/clear controller, with these additions:
  - Enable is synchronised and edge-detected; it is no longer used as a clock.
  - Range-select width and pulse widths are parameters.
  - Adds inhibit, missed-window reporting and a cycle-done strobe.

---
 rtl/gate_store_clear_seq.sv | 204 ++++++++++++++++++++
 tb/tb_gate_store_clear_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_store_clear_seq.sv
// gate_store_clear_seq: store/clear sequencer for the freq/period meter.
// Optional outputs range_up/range_dir are built when RANGE_REQ_EN is defined.
module gate_store_clear_seq #(
  parameter int STORE_W     = 5000000,
  parameter int CLEAR_W     = 20,
  parameter int SEL_W       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK_50,
  input  logic             RST,
  input  logic             Enable,
  input  logic             OF,
  input  logic             measure_mode,
  input  logic [SEL_W-1:0] F_sel,
  input  logic [SEL_W-1:0] T_sel,
  input  logic             inhibit,
  output logic             Store,
  output logic             Clear,
  output logic [1:0]       Status_Value,
  output logic             missed,
  output logic             done
`ifdef RANGE_REQ_EN
  ,
  output logic             range_up,
  output logic             range_dir
`endif
);

  localparam int SCW = $clog2(STORE_W + 1);
  localparam int CCW = $clog2(CLEAR_W + 1);
  localparam logic [SCW-1:0] S_TC = SCW'(STORE_W - 1);
  localparam logic [CCW-1:0] C_TC = CCW'(CLEAR_W - 1);
  localparam logic [SEL_W-1:0] SEL_ONES = '1;
  localparam logic [SEL_W-1:0] SEL_ZERO = '0;

  localparam logic [1:0] ST_READY = 2'b11;
  localparam logic [1:0] ST_STORE = 2'b01;
  localparam logic [1:0] ST_CLEAR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATE,
    S_STORE,
    S_CLEAR
  } state_t;

  state_t r_state;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_en_d;
  logic                   w_en_s;
  logic                   w_rise;
  logic                   w_fall;

  logic [SCW-1:0]   r_scnt;
  logic [CCW-1:0]   r_ccnt;
  logic [SEL_W-1:0] r_fsel_l;
  logic [SEL_W-1:0] r_tsel_l;
  logic             r_mode_l;
  logic             r_inh_l;
  logic             r_ovf_l;
  logic             r_first;
  logic             w_skip;

  logic       r_store;
  logic       r_clear;
  logic [1:0] r_status;
  logic       r_missed;
  logic       r_done;

  assign w_en_s = r_sync[SYNC_STAGES-1];
  assign w_rise = w_en_s & ~r_en_d;
  assign w_fall = ~w_en_s & r_en_d;

  // Overflowed window whose range can still be moved -> discard counts.
  assign w_skip = r_ovf_l &
                  ((~r_mode_l & (r_fsel_l != SEL_ONES)) |
                   ( r_mode_l & (r_tsel_l != SEL_ZERO)));

  // Bring the asynchronous gate into the clock domain and keep one delayed copy.
  always_ff @(posedge CLK_50 or posedge RST) begin
    if (RST) begin
      r_sync <= '0;
      r_en_d <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], Enable};
      r_en_d <= w_en_s;
    end
  end

`ifdef RANGE_REQ_EN
  logic r_range_up;
  logic r_range_dir;

  // Ask the range logic to step when an overflowed window was discarded.
  always_ff @(posedge CLK_50 or posedge RST) begin
    if (RST) begin
      r_range_up  <= 1'b0;
      r_range_dir <= 1'b0;
    end else begin
      r_range_up <= 1'b0;
      if (r_state == S_GATE && w_fall && !r_inh_l &&
          !r_first && w_skip) begin
        r_range_up  <= 1'b1;
        r_range_dir <= r_mode_l;
      end
    end
  end

  assign range_up  = r_range_up;
  assign range_dir = r_range_dir;
`endif

  // Main sequencer: gate tracking, store pulse, clear pulse, strobes.
  always_ff @(posedge CLK_50 or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_scnt   <= '0;
      r_ccnt   <= '0;
      r_fsel_l <= '0;
      r_tsel_l <= '0;
      r_mode_l <= 1'b0;
      r_inh_l  <= 1'b0;
      r_ovf_l  <= 1'b0;
      r_first  <= 1'b1;
      r_store  <= 1'b0;
      r_clear  <= 1'b0;
      r_status <= ST_READY;
      r_missed <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_missed <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_fsel_l <= F_sel;
            r_tsel_l <= T_sel;
            r_mode_l <= measure_mode;
            r_inh_l  <= inhibit;
            r_ovf_l  <= 1'b0;
            r_state  <= S_GATE;
          end
        end
        S_GATE: begin
          r_ovf_l <= r_ovf_l | OF;
          if (w_fall) begin
            if (r_inh_l) begin
              r_state <= S_IDLE;
            end else if (r_first || w_skip) begin
              r_first  <= 1'b0;
              r_ccnt   <= '0;
              r_clear  <= 1'b1;
              r_status <= ST_CLEAR;
              r_state  <= S_CLEAR;
            end else begin
              r_first  <= 1'b0;
              r_scnt   <= '0;
              r_store  <= 1'b1;
              r_status <= ST_STORE;
              r_state  <= S_STORE;
            end
          end
        end
        S_STORE: begin
          r_missed <= w_rise;
          if (r_scnt == S_TC) begin
            r_store  <= 1'b0;
            r_ccnt   <= '0;
            r_clear  <= 1'b1;
            r_status <= ST_CLEAR;
            r_state  <= S_CLEAR;
          end else begin
            r_scnt <= r_scnt + 1'b1;
          end
        end
        S_CLEAR: begin
          r_missed <= w_rise;
          if (r_ccnt == C_TC) begin
            r_clear  <= 1'b0;
            r_done   <= 1'b1;
            r_status <= ST_READY;
            r_state  <= S_IDLE;
          end else begin
            r_ccnt <= r_ccnt + 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_store  <= 1'b0;
          r_clear  <= 1'b0;
          r_status <= ST_READY;
        end
      endcase
    end
  end

  assign Store        = r_store;
  assign Clear        = r_clear;
  assign Status_Value = r_status;
  assign missed       = r_missed;
  assign done         = r_done;

endmodule

// File: tb/tb_gate_store_clear_seq.sv
// tb_gate_store_clear_seq: scoreboard bench for gate_store_clear_seq.
// Expected pulse events are queued per window and matched by a monitor.
module tb_gate_store_clear_seq;

  localparam int SW = 8;
  localparam int CW = 3;

  localparam int K_MISSED = 1;
  localparam int K_STORE  = 2;
  localparam int K_CLEAR  = 3;
  localparam int K_DONE   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       of;
  logic       mode;
  logic       inh;
  logic [1:0] fsel;
  logic [1:0] tsel;
  logic       store;
  logic       clr;
  logic [1:0] status;
  logic       missed;
  logic       done;
`ifdef RANGE_REQ_EN
  logic       ru;
  logic       rd;
`endif

  always #5 clk = ~clk;

  gate_store_clear_seq #(
    .STORE_W(SW),
    .CLEAR_W(CW),
    .SEL_W(2),
    .SYNC_STAGES(2)
  ) dut (
    .CLK_50(clk),
    .RST(rst),
    .Enable(en),
    .OF(of),
    .measure_mode(mode),
    .F_sel(fsel),
    .T_sel(tsel),
    .inhibit(inh),
    .Store(store),
    .Clear(clr),
    .Status_Value(status),
    .missed(missed),
    .done(done)
`ifdef RANGE_REQ_EN
    ,
    .range_up(ru),
    .range_dir(rd)
`endif
  );

  typedef struct {
    int kind;
    int width;
    bit st_ok;
  } ev_t;

  ev_t q[$];
  int  errors = 0;
  int  checks = 0;
  bit  first_win;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(int kind, int width);
    ev_t e;
    e.kind  = kind;
    e.width = width;
    e.st_ok = 1'b1;
    q.push_back(e);
  endtask

  // Reference: outcome of one closed gate window from the meter rules.
  task automatic model_window(bit i_inh, bit i_mode, int f, int t,
                              bit ovf, bit mis);
    bit skip;
    if (mis) push(K_MISSED, 1);
    if (i_inh) return;
    skip = ovf && ((!i_mode && f != 3) || (i_mode && t != 0));
    if (!(first_win || skip)) push(K_STORE, SW);
    push(K_CLEAR, CW);
    push(K_DONE, 1);
    first_win = 1'b0;
  endtask

  task automatic emit(int kind, int width, bit ok);
    ev_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse: kind %0d width %0d, none expected",
               kind, width);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("pulse_width", width, e.width);
      chk("status_during_pulse", int'(ok), int'(e.st_ok));
    end
  endtask

  int w[4];
  bit ok[4];
  logic [3:0] sig;

  // Monitor: measure every output pulse and match it to the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        w[i]  = 0;
        ok[i] = 1'b1;
      end
    end else begin
      sig = {done, clr, store, missed};
      if (store || clr) chk("store_clear_overlap", int'(store && clr), 0);
      for (int i = 0; i < 4; i++) begin
        if (sig[i]) begin
          w[i]++;
          if (i == 1 && status != 2'b01) ok[i] = 1'b0;
          if (i == 2 && status != 2'b10) ok[i] = 1'b0;
        end else if (w[i] > 0) begin
          emit(i + 1, w[i], ok[i]);
          w[i]  = 0;
          ok[i] = 1'b1;
        end
      end
    end
  end

  task automatic window(int len, bit i_inh, bit i_mode, int f, int t,
                        bit ofv, bit mis);
    @(posedge clk);
    #2;
    fsel = 2'(f);
    tsel = 2'(t);
    mode = i_mode;
    inh  = i_inh;
    en   = 1'b1;
    of   = ofv;
    repeat (len) @(posedge clk);
    #2;
    model_window(i_inh, i_mode, f, t, ofv, mis);
    en   = 1'b0;
    of   = 1'b0;
    fsel = 2'($urandom);
    tsel = 2'($urandom);
    mode = 1'($urandom);
    inh  = 1'($urandom);
  endtask

  task automatic settle(int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_store(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(posedge clk);
      #1;
      seen = store;
    end
    chk("store_seen_in_time", int'(seen), 1);
  endtask

  bit seen;

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    of   = 1'b0;
    mode = 1'b0;
    inh  = 1'b0;
    fsel = 2'b00;
    tsel = 2'b00;
    first_win = 1'b1;
    settle(3);
    #1;
    chk("rst_store", int'(store), 0);
    chk("rst_clear", int'(clr), 0);
    chk("rst_status", int'(status), 3);
    chk("rst_missed", int'(missed), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;

    window(20, 0, 0, 0, 0, 0, 0);
    settle(25);
    #1;
    chk("status_after_first", int'(status), 3);

    window(10, 0, 0, 0, 0, 0, 0);
    settle(25);

    window(10, 0, 0, 1, 0, 1, 0);
    settle(25);
`ifdef RANGE_REQ_EN
    #1;
    chk("range_dir_freq", int'(rd), 0);
`endif

    window(10, 0, 1, 0, 0, 1, 0);
    settle(25);
    window(10, 0, 0, 3, 2, 1, 0);
    settle(25);

    window(10, 1, 0, 0, 0, 0, 0);
    settle(25);
    #1;
    chk("status_inhibit", int'(status), 3);
    window(10, 0, 0, 0, 0, 0, 0);
    settle(25);

    window(8, 0, 0, 0, 0, 0, 1);
    wait_store(seen);
    @(posedge clk);
    #2;
    en = 1'b1;
    settle(2);
    #2;
    en = 1'b0;
    settle(25);

    window(8, 0, 0, 0, 0, 0, 0);
    wait_store(seen);
    settle(3);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_store", int'(store), 0);
    chk("rst_mid_status", int'(status), 3);
    q.delete();
    first_win = 1'b1;
    settle(2);
    #2;
    rst = 1'b0;
    window(12, 0, 0, 0, 0, 0, 0);
    settle(25);

    for (int i = 0; i < 40; i++) begin
      window($urandom_range(6, 20), ($urandom_range(0, 4) == 0),
             1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom), 0);
      settle(22 + $urandom_range(0, 5));
    end

    settle(30);
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
